rv16_sub_unit: RTL

Multi-cycle, digit-serial subtractor for the rv16 datapath, complementing the ripple-carry adder unit. It computes rd = rs1 − rs2 − borrow_in over DATA/DIGIT cycles, processing DIGIT bits per cycle LSB-first with a registered borrow chain. It exposes a start/busy/done handshake to the ALU sequencer and delivers unsigned borrow, signed overflow and zero flags with the result.

---
 rtl/rv16_alu_pkg.sv | 17 +
 rtl/rv16_sub_digit.sv | 28 ++
 rtl/rv16_sub_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rv16_alu_pkg.sv
// rv16_alu_pkg
//   Shared definitions for the rv16 ALU units: default datapath widths and
//   the sequencing state encoding used by the multi-cycle units.
package rv16_alu_pkg;

  // Architectural register width of the rv16 datapath.
  localparam int RV16_XLEN      = 16;
  // Default digit width for the digit-serial units.
  localparam int RV16_SUB_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage : rv16_alu_pkg

// File: rtl/rv16_sub_digit.sv
// rv16_sub_digit
//   Purely combinational DIGIT-bit subtractor: diff = a - b - bin.
//   Implemented in carry form (a + ~b + ~bin), so the borrow out is the
//   inverted carry out of the top bit.
// Ports:
//   a, b  : DIGIT-bit minuend / subtrahend digits
//   bin   : borrow in from the previous (less significant) digit
//   diff  : DIGIT-bit difference digit
//   bout  : borrow out to the next digit
module rv16_sub_digit
  import rv16_alu_pkg::*;
#(
  parameter int DIGIT = RV16_SUB_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);

  logic [DIGIT:0] sum;

  assign sum  = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, ~bin};
  assign diff = sum[DIGIT-1:0];
  assign bout = ~sum[DIGIT];

endmodule : rv16_sub_digit

// File: rtl/rv16_sub_unit.sv
// rv16_sub_unit
//   Digit-serial subtractor: rd = rs1 - rs2 - rp_bin, processed DIGIT bits
//   per cycle LSB-first over N = DATA/DIGIT cycles with a registered borrow.
//   start/busy/done handshake; results and flags are registered and only
//   change in the done cycle.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : operation request, honoured only when not busy
//   rs1_sub_in   : minuend, sampled with an accepted start
//   rs2_sub_in   : subtrahend, sampled with an accepted start
//   rp_bin       : borrow in, sampled with an accepted start
//   busy         : operation in progress
//   done         : one-cycle pulse, results valid from this cycle
//   rd_sub_out   : difference
//   rp_bout      : unsigned borrow out
//   rp_zero      : difference is zero
//   rp_ovf       : signed overflow
module rv16_sub_unit
  import rv16_alu_pkg::*;
#(
  parameter int DATA  = RV16_XLEN,
  parameter int DIGIT = RV16_SUB_DIGIT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DATA-1:0] rs1_sub_in,
  input  logic [DATA-1:0] rs2_sub_in,
  input  logic            rp_bin,
  output logic            busy,
  output logic            done,
  output logic [DATA-1:0] rd_sub_out,
  output logic            rp_bout,
  output logic            rp_zero,
  output logic            rp_ovf
);

  localparam int N     = DATA / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  if ((DIGIT < 1) || (DATA % DIGIT != 0)) begin : g_bad_digit
    $error("rv16_sub_unit: DATA (%0d) must be a non-zero multiple of DIGIT (%0d)",
           DATA, DIGIT);
  end

  alu_state_t       state;
  logic [DATA-1:0]  a_sr;      // minuend, shifted right one digit per cycle
  logic [DATA-1:0]  b_sr;      // subtrahend, shifted right one digit per cycle
  logic [DATA-1:0]  res_sr;    // result digits enter at the top
  logic             borrow;
  logic [CNT_W-1:0] cnt;

  logic [DIGIT-1:0] dig_diff;
  logic             dig_bout;
  logic [DATA-1:0]  res_next;

  rv16_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .bin  (borrow),
    .diff (dig_diff),
    .bout (dig_bout)
  );

  // After the last digit the result register holds the complete difference,
  // LSB digit at the bottom.
  if (N == 1) begin : g_single_digit
    assign res_next = dig_diff;
  end else begin : g_multi_digit
    assign res_next = {dig_diff, res_sr[DATA-1:DIGIT]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, so a reset mid-operation
      // leaves no stale operand or borrow state behind.
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_sub_out <= '0;
      rp_bout    <= 1'b0;
      rp_zero    <= 1'b0;
      rp_ovf     <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr   <= rs1_sub_in;
            b_sr   <= rs2_sub_in;
            borrow <= rp_bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          borrow <= dig_bout;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_DIGIT) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
            rd_sub_out <= res_next;
            rp_bout    <= dig_bout;
            rp_zero    <= (res_next == '0);
            // The low digit now holds the operands' top digits, so its MSB
            // is the sign bit of each operand.
            rp_ovf     <= (a_sr[DIGIT-1] != b_sr[DIGIT-1]) &&
                          (dig_diff[DIGIT-1] != a_sr[DIGIT-1]);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : rv16_sub_unit
